// File: rtl/bram_rr_port_arbiter.sv
// Round-robin front end that lets two requesters share one single-port BRAM.
// Define BRAM_ARB_STATS_EN to add the per-port grant counters grant_cnt0/grant_cnt1.
module bram_rr_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                  axi_clock,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req0_we,
  input  logic [DATA_WIDTH-1:0] req0_din,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_we,
  input  logic [DATA_WIDTH-1:0] req1_din,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  bram_en,
  output logic                  bram_we
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [31:0]           grant_cnt0,
  output logic [31:0]           grant_cnt1
`endif
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("bram_rr_port_arbiter: RD_LATENCY must be in 1..4");
  end

  logic                  last_gnt_q;
  logic                  last_gnt_d;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rd_push;
  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [RD_LATENCY-1:0] tag_vld_d;
  logic [RD_LATENCY-1:0] tag_id_q;
  logic [RD_LATENCY-1:0] tag_id_d;

  // Under contention the port that did not win last time goes first.
  assign gnt0 = req0_valid & (~req1_valid | last_gnt_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_gnt_q);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign bram_addr = gnt1 ? req1_addr : req0_addr;
  assign bram_din  = gnt1 ? req1_din  : req0_din;
  assign bram_en   = gnt0 | gnt1;
  assign bram_we   = (gnt0 & req0_we) | (gnt1 & req1_we);

  assign last_gnt_d = bram_en ? gnt1 : last_gnt_q;
  assign rd_push    = bram_en & ~bram_we;

  // Tag pipeline tracks which port owns the data emerging from the BRAM.
  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      assign tag_vld_d[gi] = rd_push;
      assign tag_id_d[gi]  = gnt1;
    end else begin : g_body
      assign tag_vld_d[gi] = tag_vld_q[gi-1];
      assign tag_id_d[gi]  = tag_id_q[gi-1];
    end
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
    end
  end

  assign rsp0_valid = tag_vld_q[RD_LATENCY-1] & ~tag_id_q[RD_LATENCY-1];
  assign rsp1_valid = tag_vld_q[RD_LATENCY-1] &  tag_id_q[RD_LATENCY-1];
  assign rsp0_data  = bram_dout;
  assign rsp1_data  = bram_dout;

`ifdef BRAM_ARB_STATS_EN
  logic [31:0] cnt0_q;
  logic [31:0] cnt1_q;
  logic [31:0] cnt0_d;
  logic [31:0] cnt1_d;

  // Counters wrap naturally at 2^32.
  assign cnt0_d = gnt0 ? cnt0_q + 32'd1 : cnt0_q;
  assign cnt1_d = gnt1 ? cnt1_q + 32'd1 : cnt1_q;

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_bram_rr_port_arbiter.sv
// Self-checking bench: three arbiters (RD_LATENCY 1, 2, 3) share one request stimulus,
// each backed by its own BRAM model, compared against a transaction-level reference.
module tb_bram_rr_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [9:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_din = '0, req1_din = '0;

  logic        r0_rdy [3];
  logic        r1_rdy [3];
  logic        s0_v   [3];
  logic        s1_v   [3];
  logic        b_en   [3];
  logic        b_we   [3];
  logic [31:0] s0_d   [3];
  logic [31:0] s1_d   [3];
  logic [31:0] b_din  [3];
  logic [31:0] b_dout [3];
  logic [9:0]  b_addr [3];
`ifdef BRAM_ARB_STATS_EN
  logic [31:0] cnt0 [3];
  logic [31:0] cnt1 [3];
`endif

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int L = gi + 1;
    logic [31:0] mem  [0:1023];
    logic [31:0] pipe [0:L-1];

    bram_rr_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_LATENCY(L)) dut (
      .axi_clock (clk),
      .rst       (rst),
      .req0_valid(req0_valid),
      .req0_ready(r0_rdy[gi]),
      .req0_addr (req0_addr),
      .req0_we   (req0_we),
      .req0_din  (req0_din),
      .req1_valid(req1_valid),
      .req1_ready(r1_rdy[gi]),
      .req1_addr (req1_addr),
      .req1_we   (req1_we),
      .req1_din  (req1_din),
      .rsp0_valid(s0_v[gi]),
      .rsp0_data (s0_d[gi]),
      .rsp1_valid(s1_v[gi]),
      .rsp1_data (s1_d[gi]),
      .bram_addr (b_addr[gi]),
      .bram_din  (b_din[gi]),
      .bram_dout (b_dout[gi]),
      .bram_en   (b_en[gi]),
      .bram_we   (b_we[gi])
`ifdef BRAM_ARB_STATS_EN
      ,
      .grant_cnt0(cnt0[gi]),
      .grant_cnt1(cnt1[gi])
`endif
    );

    // Read-first single-port BRAM with L cycles from enable to data.
    always @(posedge clk) begin
      if (b_en[gi]) begin
        pipe[0] <= mem[b_addr[gi]];
        if (b_we[gi]) mem[b_addr[gi]] <= b_din[gi];
      end
      for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
    end
    assign b_dout[gi] = pipe[L-1];
  end

  // Reference model state
  typedef struct {
    int          due;
    bit          port;
    bit          known;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rq [3][$];
  logic [31:0] ref_mem [int];
  int          cyc = 0;
  bit          last_m = 1'b1;
  int unsigned m_cnt0 = 0, m_cnt1 = 0;

  bit          e_rdy0, e_rdy1, e_en, e_we;
  logic [9:0]  e_addr;
  logic [31:0] e_din;
  bit          e_rv0 [3];
  bit          e_rv1 [3];
  bit          e_known [3];
  logic [31:0] e_data [3];
  int unsigned e_cnt0, e_cnt1;

  int total = 0;
  int bad   = 0;

  // One clock cycle: drive inputs, predict this cycle's outputs, commit the model, sample at negedge.
  task automatic cycle(input bit r, input bit v0, input bit we0, input logic [9:0] a0,
                       input logic [31:0] d0, input bit v1, input bit we1,
                       input logic [9:0] a1, input logic [31:0] d1);
    int   win;
    rsp_t e;
    @(posedge clk); #1;
    rst = r;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_din = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_din = d1;

    if (v0 && v1) win = last_m ? 0 : 1;
    else if (v0)  win = 0;
    else if (v1)  win = 1;
    else          win = -1;
    e_rdy0 = (win == 0);
    e_rdy1 = (win == 1);
    e_en   = (win >= 0);
    e_we   = (win == 0) ? we0 : (win == 1) ? we1 : 1'b0;
    e_addr = (win == 1) ? a1 : a0;
    e_din  = (win == 1) ? d1 : d0;
    e_cnt0 = m_cnt0;
    e_cnt1 = m_cnt1;

    for (int k = 0; k < 3; k++) begin
      e_rv0[k] = 1'b0; e_rv1[k] = 1'b0; e_known[k] = 1'b0; e_data[k] = '0;
      if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
        e = rq[k].pop_front();
        e_rv0[k]   = (e.port == 1'b0);
        e_rv1[k]   = (e.port == 1'b1);
        e_known[k] = e.known;
        e_data[k]  = e.data;
      end
    end

    if (win >= 0)
      $display("[%0t] xfer port=%0d %s addr=0x%03h din=0x%08h rst=%0d",
               $time, win, e_we ? "WR" : "RD", e_addr, e_din, r);

    if (win >= 0 && !e_we) begin
      e.port  = (win == 1);
      e.known = ref_mem.exists(int'(e_addr));
      e.data  = e.known ? ref_mem[int'(e_addr)] : '0;
      if (!r)
        for (int k = 0; k < 3; k++) begin
          e.due = cyc + k + 1;
          rq[k].push_back(e);
        end
    end
    if (win >= 0 && e_we) ref_mem[int'(e_addr)] = e_din;

    if (r) begin
      for (int k = 0; k < 3; k++) rq[k].delete();
      last_m = 1'b1;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else if (win >= 0) begin
      last_m = (win == 1);
      if (win == 0) m_cnt0++;
      else          m_cnt1++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input bit r);
    cycle(r, 0, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 10'h02A, 32'h0, 0, 0, 10'h155, 32'h0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (s0_v[k] !== 1'b0 || s1_v[k] !== 1'b0)
        begin bad++; $display("FAIL reset_rsp L=%0d got=%b%b want=00", k+1, s0_v[k], s1_v[k]); end
      total++;
      if (b_en[k] !== 1'b0 || b_we[k] !== 1'b0 || r0_rdy[k] !== 1'b0 || r1_rdy[k] !== 1'b0)
        begin bad++; $display("FAIL reset_idle L=%0d en=%b we=%b rdy=%b%b want all 0", k+1, b_en[k], b_we[k], r0_rdy[k], r1_rdy[k]); end
      total++;
      if (b_addr[k] !== 10'h02A)
        begin bad++; $display("FAIL reset_addr L=%0d got=0x%03h want=0x02A", k+1, b_addr[k]); end
    end
    idle(0);
  endtask

  task automatic test_single_read();
    cycle(0, 1, 1, 10'h005, 32'hDEADBEEF, 0, 0, 10'h0, 32'h0);
    total++;
    if (r0_rdy[0] !== 1'b1 || b_we[0] !== 1'b1)
      begin bad++; $display("FAIL single_wr got rdy=%b we=%b want 1 1", r0_rdy[0], b_we[0]); end
    cycle(0, 1, 0, 10'h005, 32'h0, 0, 0, 10'h0, 32'h0);
    total++;
    if (r0_rdy[0] !== 1'b1 || b_we[0] !== 1'b0 || b_en[0] !== 1'b1)
      begin bad++; $display("FAIL single_rd_grant got rdy=%b we=%b en=%b want 1 0 1", r0_rdy[0], b_we[0], b_en[0]); end
    idle(0);
    total++;
    if (s0_v[0] !== 1'b1 || s0_d[0] !== 32'hDEADBEEF || s1_v[0] !== 1'b0)
      begin bad++; $display("FAIL single_rsp got v0=%b d=0x%08h v1=%b want 1 0xDEADBEEF 0", s0_v[0], s0_d[0], s1_v[0]); end
    idle(0);
    total++;
    if (s0_v[0] !== 1'b0)
      begin bad++; $display("FAIL single_pulse got v0=%b want 0", s0_v[0]); end
    for (int i = 0; i < 3; i++) idle(0);
  endtask

  task automatic test_contention();
    idle(1);
    idle(1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 1, 10'h100 + 10'(i), $urandom, 1, 0, 10'h200 + 10'(i), 32'h0);
      total++;
      if (r0_rdy[0] !== (i % 2 == 0) || r1_rdy[0] !== (i % 2 == 1))
        begin bad++; $display("FAIL contention_order i=%0d got rdy=%b%b want port %0d", i, r0_rdy[0], r1_rdy[0], i % 2); end
      total++;
      if (b_we[0] !== (i % 2 == 0))
        begin bad++; $display("FAIL contention_we i=%0d got=%b want=%b", i, b_we[0], i % 2 == 0); end
      total++;
      if (s0_v[0] !== 1'b0 || s1_v[0] !== (i == 2 || i == 4))
        begin bad++; $display("FAIL contention_rsp i=%0d got v0=%b v1=%b want 0 %b", i, s0_v[0], s1_v[0], i == 2 || i == 4); end
    end
    for (int i = 0; i < 4; i++) idle(0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    for (int j = 0; j < 3; j++) begin
      vals[j] = $urandom;
      cycle(0, 0, 0, 10'h0, 32'h0, 1, 1, 10'h010 + 10'(j), vals[j]);
    end
    for (int j = 0; j < 7; j++) begin
      if (j < 3) cycle(0, 0, 0, 10'h0, 32'h0, 1, 0, 10'h010 + 10'(j), 32'h0);
      else       idle(0);
      total++;
      if (s1_v[2] !== (j >= 3 && j <= 5) || s0_v[2] !== 1'b0)
        begin bad++; $display("FAIL b2b_valid j=%0d got v1=%b v0=%b want %b 0", j, s1_v[2], s0_v[2], j >= 3 && j <= 5); end
      if (j >= 3 && j <= 5) begin
        total++;
        if (s1_d[2] !== vals[j-3])
          begin bad++; $display("FAIL b2b_data j=%0d got=0x%08h want=0x%08h", j, s1_d[2], vals[j-3]); end
      end
    end
  endtask

  task automatic test_write_then_read();
    cycle(0, 0, 0, 10'h0, 32'h0, 1, 1, 10'h3FF, 32'h12345678);
    cycle(0, 1, 0, 10'h3FF, 32'h0, 0, 0, 10'h0, 32'h0);
    total++;
    if (r0_rdy[0] !== 1'b1 || b_addr[0] !== 10'h3FF)
      begin bad++; $display("FAIL wtr_grant got rdy=%b addr=0x%03h want 1 0x3FF", r0_rdy[0], b_addr[0]); end
    idle(0);
    total++;
    if (s0_v[0] !== 1'b1 || s0_d[0] !== 32'h12345678)
      begin bad++; $display("FAIL wtr_l1 got v=%b d=0x%08h want 1 0x12345678", s0_v[0], s0_d[0]); end
    idle(0);
    total++;
    if (s0_v[1] !== 1'b1 || s0_d[1] !== 32'h12345678)
      begin bad++; $display("FAIL wtr_l2 got v=%b d=0x%08h want 1 0x12345678", s0_v[1], s0_d[1]); end
    for (int i = 0; i < 3; i++) idle(0);
  endtask

  task automatic test_reset_midflight();
    cycle(0, 1, 0, 10'h005, 32'h0, 0, 0, 10'h0, 32'h0);
    cycle(1, 0, 0, 10'h0, 32'h0, 1, 0, 10'h010, 32'h0);
    for (int j = 0; j < 5; j++) begin
      for (int k = 1; k < 3; k++) begin
        total++;
        if (s0_v[k] !== 1'b0 || s1_v[k] !== 1'b0)
          begin bad++; $display("FAIL midrst_drop L=%0d j=%0d got=%b%b want=00", k+1, j, s0_v[k], s1_v[k]); end
      end
      idle(0);
    end
    cycle(0, 1, 0, 10'h001, 32'h0, 1, 0, 10'h002, 32'h0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (r0_rdy[k] !== 1'b1 || r1_rdy[k] !== 1'b0)
        begin bad++; $display("FAIL midrst_first L=%0d got rdy=%b%b want 10", k+1, r0_rdy[k], r1_rdy[k]); end
    end
    for (int i = 0; i < 4; i++) idle(0);
  endtask

`ifdef BRAM_ARB_STATS_EN
  task automatic test_stats();
    idle(1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 10'h020 + 10'(i), $urandom, 0, 0, 10'h0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 10'h0, 32'h0, 1, 1, 10'h030 + 10'(i), $urandom);
    idle(0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cnt0[k] !== 32'd5 || cnt1[k] !== 32'd3)
        begin bad++; $display("FAIL stats_count L=%0d got=%0d/%0d want=5/3", k+1, cnt0[k], cnt1[k]); end
    end
    idle(1);
    idle(0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cnt0[k] !== 32'd0 || cnt1[k] !== 32'd0)
        begin bad++; $display("FAIL stats_reset L=%0d got=%0d/%0d want=0/0", k+1, cnt0[k], cnt1[k]); end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) < 7), $urandom_range(0, 1), 10'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 9) < 7), $urandom_range(0, 1), 10'($urandom_range(0, 15)), $urandom);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (r0_rdy[k] !== e_rdy0 || r1_rdy[k] !== e_rdy1)
          begin bad++; $display("FAIL rand_grant L=%0d i=%0d got=%b%b want=%b%b", k+1, i, r0_rdy[k], r1_rdy[k], e_rdy0, e_rdy1); end
        total++;
        if (b_en[k] !== e_en || b_we[k] !== e_we || b_addr[k] !== e_addr || b_din[k] !== e_din)
          begin bad++; $display("FAIL rand_bram L=%0d i=%0d got en=%b we=%b a=0x%03h d=0x%08h want en=%b we=%b a=0x%03h d=0x%08h",
                                k+1, i, b_en[k], b_we[k], b_addr[k], b_din[k], e_en, e_we, e_addr, e_din); end
        total++;
        if (s0_v[k] !== e_rv0[k] || s1_v[k] !== e_rv1[k])
          begin bad++; $display("FAIL rand_rspv L=%0d i=%0d got=%b%b want=%b%b", k+1, i, s0_v[k], s1_v[k], e_rv0[k], e_rv1[k]); end
        if (e_known[k]) begin
          total++;
          if ((e_rv0[k] ? s0_d[k] : s1_d[k]) !== e_data[k])
            begin bad++; $display("FAIL rand_data L=%0d i=%0d got=0x%08h want=0x%08h", k+1, i, e_rv0[k] ? s0_d[k] : s1_d[k], e_data[k]); end
        end
`ifdef BRAM_ARB_STATS_EN
        total++;
        if (cnt0[k] !== e_cnt0 || cnt1[k] !== e_cnt1)
          begin bad++; $display("FAIL rand_cnt L=%0d i=%0d got=%0d/%0d want=%0d/%0d", k+1, i, cnt0[k], cnt1[k], e_cnt0, e_cnt1); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_write_then_read();
    test_reset_midflight();
`ifdef BRAM_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
